// File: rtl/iob_norm.sv
`default_nettype none
// ============================================================================
// Module   : iob_norm (with helper iob_ctls)
// Brief    : Two-stage pipelined mantissa normalizer with valid/ready flow
//            control, leading-zero driven left shift and exponent clamping.
// Revision : 1.0 - initial release
// ============================================================================

module iob_ctls #(
    parameter int W      = 24,
    parameter int MODE   = 1,
    parameter int SYMBOL = 0
) (
    input  logic [W-1:0]         data_i,
    output logic [$clog2(W):0]   count_o
);
    localparam int c_cnt_w = $clog2(W) + 1;

    logic [c_cnt_w-1:0] w_count;
    logic               w_found;

    // MODE=1 scans from the MSB (leading), MODE=0 from the LSB (trailing)
    always_comb begin
        w_count = c_cnt_w'(W);
        w_found = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (!w_found && (data_i[(MODE != 0) ? (W - 1 - i) : i] != 1'(SYMBOL))) begin
                w_count = c_cnt_w'(i);
                w_found = 1'b1;
            end
        end
    end

    assign count_o = w_count;
endmodule

module iob_norm #(
    parameter int DATA_W = 24,
    parameter int EXP_W  = 8
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    input  logic [EXP_W-1:0]  exp_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic [EXP_W-1:0]  exp_o,
    output logic              zero_o,
    output logic              uflow_o
);
    localparam int c_lz_w  = $clog2(DATA_W) + 1;
    localparam int c_cmp_w = (EXP_W > c_lz_w) ? EXP_W : c_lz_w;

    logic [c_lz_w-1:0]  w_lz;
    logic               w_adv1;
    logic               w_adv2;

    logic               r_s1_v;
    logic [DATA_W-1:0]  r_s1_data;
    logic [EXP_W-1:0]   r_s1_exp;
    logic [c_lz_w-1:0]  r_s1_lz;

    logic               r_s2_v;
    logic [DATA_W-1:0]  r_s2_data;
    logic [EXP_W-1:0]   r_s2_exp;
    logic               r_s2_zero;
    logic               r_s2_uflow;

    logic [c_cmp_w-1:0] w_lz_ext;
    logic [c_cmp_w-1:0] w_exp_ext;
    logic [c_cmp_w-1:0] w_sh;
    logic [c_cmp_w-1:0] w_exp_sub;
    logic [DATA_W-1:0]  w_data_sh;
    logic               w_is_zero;
    logic               w_uflow;

    iob_ctls #(
        .W      (DATA_W),
        .MODE   (1),
        .SYMBOL (0)
    ) u_ctls (
        .data_i  (data_i),
        .count_o (w_lz)
    );

    // No skid buffer: input readiness follows downstream readiness combinationally
    assign w_adv2  = !r_s2_v || ready_i;
    assign w_adv1  = !r_s1_v || w_adv2;
    assign ready_o = w_adv1;

    // Shift is limited by the exponent so the subtraction can never wrap
    assign w_lz_ext  = c_cmp_w'(r_s1_lz);
    assign w_exp_ext = c_cmp_w'(r_s1_exp);
    assign w_is_zero = (r_s1_lz == c_lz_w'(DATA_W));
    assign w_sh      = (w_lz_ext < w_exp_ext) ? w_lz_ext : w_exp_ext;
    assign w_data_sh = r_s1_data << w_sh;
    assign w_exp_sub = w_exp_ext - w_sh;
    assign w_uflow   = (w_lz_ext > w_exp_ext);

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_s1_v     <= 1'b0;
            r_s1_data  <= '0;
            r_s1_exp   <= '0;
            r_s1_lz    <= '0;
            r_s2_v     <= 1'b0;
            r_s2_data  <= '0;
            r_s2_exp   <= '0;
            r_s2_zero  <= 1'b0;
            r_s2_uflow <= 1'b0;
        end else begin
            if (w_adv2) begin
                r_s2_v     <= r_s1_v;
                r_s2_data  <= w_is_zero ? '0 : w_data_sh;
                r_s2_exp   <= w_is_zero ? '0 : w_exp_sub[EXP_W-1:0];
                r_s2_zero  <= w_is_zero;
                r_s2_uflow <= !w_is_zero && w_uflow;
            end
            if (w_adv1) begin
                r_s1_v    <= valid_i;
                r_s1_data <= data_i;
                r_s1_exp  <= exp_i;
                r_s1_lz   <= w_lz;
            end
        end
    end

    assign valid_o = r_s2_v;
    assign data_o  = r_s2_data;
    assign exp_o   = r_s2_exp;
    assign zero_o  = r_s2_zero;
    assign uflow_o = r_s2_uflow;
endmodule

`default_nettype wire

// File: tb/tb_iob_norm.sv
`default_nettype none
// ============================================================================
// Module   : tb_iob_norm
// Brief    : Scoreboard bench for iob_norm: driver pushes expectations, a
//            negedge monitor pops and compares on every output transfer.
// Revision : 1.0 - initial release
// ============================================================================

module tb_iob_norm;
    typedef struct packed {
        logic [23:0] d;
        logic [7:0]  e;
        logic        z;
        logic        u;
    } exp_t;

    logic        clk = 1'b0;
    logic        arst_i;
    logic        valid_i;
    logic        ready_o;
    logic [23:0] data_i;
    logic [7:0]  exp_i;
    logic        valid_o;
    logic        ready_i;
    logic [23:0] data_o;
    logic [7:0]  exp_o;
    logic        zero_o;
    logic        uflow_o;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t q[$];
    int   pop_cyc[$];
    exp_t held;
    logic have_held = 1'b0;

    iob_norm #(.DATA_W(24), .EXP_W(8)) dut (
        .clk_i   (clk),
        .arst_i  (arst_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .exp_i   (exp_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o),
        .exp_o   (exp_o),
        .zero_o  (zero_o),
        .uflow_o (uflow_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Bit-serial normalization, independent of any leading-zero counter
    function automatic exp_t model(input logic [23:0] d, input logic [7:0] e);
        exp_t r;
        logic [23:0] m = d;
        logic [7:0]  x = e;
        if (d == 24'd0) begin
            r.d = 24'd0; r.e = 8'd0; r.z = 1'b1; r.u = 1'b0;
        end else begin
            while (!m[23] && x != 8'd0) begin
                m = m << 1;
                x = x - 8'd1;
            end
            r.d = m; r.e = x; r.z = 1'b0; r.u = !m[23];
        end
        return r;
    endfunction

    function automatic exp_t mk(input logic [23:0] d, input logic [7:0] e, input logic z, input logic u);
        exp_t r;
        r.d = d; r.e = e; r.z = z; r.u = u;
        return r;
    endfunction

    always @(negedge clk) begin
        exp_t got;
        got = {data_o, exp_o, zero_o, uflow_o};
        if (valid_o && ready_i) begin
            if (q.size() == 0) begin
                chk("unexpected output", {30'd0, got}, 64'hdead);
            end else begin
                chk("result", {30'd0, got}, {30'd0, q.pop_front()});
                pop_cyc.push_back(cyc);
            end
        end
        if (valid_o && !ready_i) begin
            if (have_held) chk("stall stable", {30'd0, got}, {30'd0, held});
            held      = got;
            have_held = 1'b1;
        end else begin
            have_held = 1'b0;
        end
    end

    task automatic send(input logic [23:0] d, input logic [7:0] e, input exp_t x, output int waits);
        logic acc = 1'b0;
        valid_i = 1'b1;
        data_i  = d;
        exp_i   = e;
        waits   = 0;
        while (!acc && waits < 200) begin
            @(negedge clk);
            if (ready_o) begin
                acc = 1'b1;
                q.push_back(x);
            end else begin
                waits++;
            end
            @(posedge clk);
            #1;
        end
        if (!acc) chk("accept timeout", 64'd0, 64'd1);
    endtask

    task automatic idle();
        valid_i = 1'b0;
        data_i  = 24'd0;
        exp_i   = 8'd0;
    endtask

    // Item enters a drained pipeline; valid_o must rise exactly one edge after acceptance
    task automatic send_lat(input logic [23:0] d, input logic [7:0] e, input exp_t x);
        int w;
        send(d, e, x, w);
        idle();
        chk("latency early valid", {63'd0, valid_o}, 64'd0);
        @(posedge clk);
        #1;
        chk("latency valid", {63'd0, valid_o}, 64'd1);
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || valid_o) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain queue", 64'(q.size()), 64'd0);
    endtask

    function automatic logic [23:0] rnd_data();
        logic [23:0] v;
        v = 24'($urandom_range(0, 24'hffffff));
        return v >> $urandom_range(0, 24);
    endfunction

    function automatic logic [7:0] rnd_exp();
        if ($urandom_range(0, 1) == 0) return 8'($urandom_range(0, 30));
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        int n0;
        int stalls;
        logic [23:0] d;
        logic [7:0]  e;

        arst_i  = 1'b1;
        ready_i = 1'b1;
        idle();
        #23;
        chk("reset valid_o", {63'd0, valid_o}, 64'd0);
        chk("reset data_o",  {40'd0, data_o},  64'd0);
        chk("reset exp_o",   {56'd0, exp_o},   64'd0);
        chk("reset zero_o",  {63'd0, zero_o},  64'd0);
        chk("reset uflow_o", {63'd0, uflow_o}, 64'd0);
        chk("reset ready_o", {63'd0, ready_o}, 64'd1);
        arst_i = 1'b0;
        @(posedge clk);
        #1;

        // Directed cases
        send_lat(24'h000100, 8'd100, mk(24'h800000, 8'd85, 1'b0, 1'b0));
        drain();
        send(24'h000001, 8'd10, mk(24'h000400, 8'd0, 1'b0, 1'b1), w);
        send(24'h000001, 8'd23, mk(24'h800000, 8'd0, 1'b0, 1'b0), w);
        send(24'h000000, 8'd50, mk(24'h000000, 8'd0, 1'b1, 1'b0), w);
        send(24'h800000, 8'd0,  mk(24'h800000, 8'd0, 1'b0, 1'b0), w);
        send(24'h400000, 8'd0,  mk(24'h400000, 8'd0, 1'b0, 1'b1), w);
        idle();
        drain();

        // Backpressure: 6 streamed items, 3-cycle stall after first output
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    d = rnd_data();
                    e = rnd_exp();
                    send(d, e, model(d, e), w);
                end
                idle();
            end
            begin
                int n = 0;
                while (!valid_o && n < 50) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                chk("bp first output", {63'd0, valid_o}, 64'd1);
                ready_i = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                chk("bp ready_o stalled", {63'd0, ready_o}, 64'd0);
                ready_i = 1'b1;
                #1;
                chk("bp ready_o release", {63'd0, ready_o}, 64'd1);
            end
        join
        drain();

        // Full rate: 100 back-to-back items
        n0     = pop_cyc.size();
        stalls = 0;
        for (int i = 0; i < 100; i++) begin
            d = rnd_data();
            e = rnd_exp();
            send(d, e, model(d, e), w);
            stalls += w;
        end
        idle();
        drain();
        chk("fullrate stalls", 64'(stalls), 64'd0);
        chk("fullrate count", 64'(pop_cyc.size() - n0), 64'd100);
        if (pop_cyc.size() >= n0 + 100)
            chk("fullrate bubbles", 64'(pop_cyc[n0 + 99] - pop_cyc[n0]), 64'd99);

        // Reset with both stages occupied
        ready_i = 1'b0;
        send(24'h000100, 8'd100, mk(24'h800000, 8'd85, 1'b0, 1'b0), w);
        send(24'h000003, 8'd5,   mk(24'h000060, 8'd0,  1'b0, 1'b1), w);
        idle();
        chk("full ready_o", {63'd0, ready_o}, 64'd0);
        chk("full valid_o", {63'd0, valid_o}, 64'd1);
        #1;
        arst_i = 1'b1;
        #1;
        chk("async rst valid_o", {63'd0, valid_o}, 64'd0);
        chk("async rst ready_o", {63'd0, ready_o}, 64'd1);
        q.delete();
        @(posedge clk);
        #3;
        arst_i  = 1'b0;
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        send_lat(24'h00F000, 8'd200, mk(24'hF00000, 8'd192, 1'b0, 1'b0));
        drain();
        repeat (3) @(posedge clk);
        #1;
        chk("no stale valid", {63'd0, valid_o}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
